// File: rtl/ucode_pkg.sv
// Shared definitions for the microcode fetch slice: microword header layout,
// loader/run state encoding and the Am2910 instruction codes.
package ucode_pkg;

   localparam int HDR_W = 20;
   localparam int ADDR_W = 12;

   // Header fields sit above the free CTRL field, MSB first.
   typedef struct packed {
      logic [3:0]  i;
      logic [2:0]  csel;
      logic        pol;
      logic [11:0] br;
   } uhdr_t;

   localparam uhdr_t JZ_WORD = '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam logic [3:0] AM_JZ   = 4'd0;
   localparam logic [3:0] AM_CJS  = 4'd1;
   localparam logic [3:0] AM_JMAP = 4'd2;
   localparam logic [3:0] AM_CJP  = 4'd3;
   localparam logic [3:0] AM_PUSH = 4'd4;
   localparam logic [3:0] AM_JSRP = 4'd5;
   localparam logic [3:0] AM_CJV  = 4'd6;
   localparam logic [3:0] AM_JRP  = 4'd7;
   localparam logic [3:0] AM_RFCT = 4'd8;
   localparam logic [3:0] AM_RPCT = 4'd9;
   localparam logic [3:0] AM_CRTN = 4'd10;
   localparam logic [3:0] AM_CJPP = 4'd11;
   localparam logic [3:0] AM_LDCT = 4'd12;
   localparam logic [3:0] AM_LOOP = 4'd13;
   localparam logic [3:0] AM_CONT = 4'd14;
   localparam logic [3:0] AM_TWB  = 4'd15;

endpackage

// File: rtl/ucode_fetch_if.sv
// Loader handshake carrying microwords into the control store.
interface ucode_fetch_if #(
   parameter int MW = 36
) ();
   logic          ld_valid;
   logic [MW-1:0] ld_data;
   logic          ld_ready;

   modport master (output ld_valid, output ld_data, input ld_ready);
   modport slave  (input ld_valid, input ld_data, output ld_ready);
endinterface

// File: rtl/ucode_store.sv
// Writable control store: synchronous write, asynchronous read, and a flag for
// microaddresses beyond the populated depth.
module ucode_store
   import ucode_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int MW    = 36
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [MW-1:0]            wdata,
   input  logic [ADDR_W-1:0]        raddr,
   output logic [MW-1:0]            rdata,
   output logic                     oor
);
   localparam int AW = $clog2(DEPTH);

   logic [MW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Extra MSB keeps the compare meaningful when DEPTH spans the full 12-bit space.
   assign oor   = ({1'b0, raddr} >= (ADDR_W+1)'(DEPTH));
   assign rdata = mem[raddr[AW-1:0]];

endmodule

// File: rtl/ucode_fetch.sv
// Consumer side of an Am2910 sequencer: control store, one-stage pipeline
// register, D-source mux, condition evaluation and the store loader FSM.
module ucode_fetch
   import ucode_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int CW    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [11:0]       Y,
   input  logic              PLn,
   input  logic              MAPn,
   input  logic              VECTn,
   input  logic [7:0]        COND,
   input  logic [11:0]       MAP_D,
   input  logic [11:0]       VECT_D,
   input  logic              ld_start,
   input  logic              run_start,
   input  logic              halt,
   ucode_fetch_if.slave      ld,
   output logic [3:0]        I,
   output logic              CCn,
   output logic [11:0]       D,
   output logic              CI,
   output logic [CW-1:0]     CTRL,
   output logic [1:0]        mode
);
   localparam int MW = HDR_W + CW;
   localparam int AW = $clog2(DEPTH);

   state_t          state, state_nxt;
   logic [AW-1:0]   ptr;
   logic            we, last_wr;
   logic [MW-1:0]   rdata;
   logic            oor;
   uhdr_t           hdr_p1;
   logic [CW-1:0]   ctrl_p1;

   assign we      = (state == ST_LOAD) && ld.ld_valid;
   assign last_wr = we && (ptr == AW'(DEPTH-1));

   ucode_store #(.DEPTH(DEPTH), .MW(MW)) u_store (
      .clk   (clk),
      .we    (we),
      .waddr (ptr),
      .wdata (ld.ld_data),
      .raddr (Y),
      .rdata (rdata),
      .oor   (oor)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && ld_start) ptr <= '0;
         else if (we)                      ptr <= ptr + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (ld_start)       state_nxt = ST_LOAD;
            else if (run_start) state_nxt = ST_RUN;
         end
         ST_LOAD: if (halt || last_wr) state_nxt = ST_IDLE;
         ST_RUN:  if (halt)            state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Fetch stage: Y in cycle n lands in the pipeline register at edge n+1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hdr_p1  <= JZ_WORD;
         ctrl_p1 <= '0;
      end else if (state == ST_RUN && !halt && !oor) begin
         hdr_p1  <= uhdr_t'(rdata[MW-1 -: HDR_W]);
         ctrl_p1 <= rdata[CW-1:0];
      end else begin
         hdr_p1  <= JZ_WORD;
         ctrl_p1 <= '0;
      end
   end

   always_comb begin
      D = '0;
      if (!PLn)        D = hdr_p1.br;
      else if (!MAPn)  D = MAP_D;
      else if (!VECTn) D = VECT_D;
   end

   assign CCn         = (hdr_p1.csel == 3'd0) ? 1'b0 : ~(COND[hdr_p1.csel] ^ hdr_p1.pol);
   assign I           = hdr_p1.i;
   assign CTRL        = ctrl_p1;
   assign CI          = (state == ST_RUN);
   assign mode        = state;
   assign ld.ld_ready = (state == ST_LOAD);

endmodule

// File: tb/tb_ucode_fetch.sv
// Directed and randomized checks of ucode_fetch against an array model of the
// control store and a cycle-level model of the fetch pipeline.
module tb_ucode_fetch;
   import ucode_pkg::*;

   localparam int DEPTH = 256;
   localparam int CW    = 16;
   localparam int MW    = 20 + CW;

   logic          clk = 1'b0;
   logic          reset;
   logic [11:0]   Y;
   logic          PLn, MAPn, VECTn;
   logic [7:0]    COND;
   logic [11:0]   MAP_D, VECT_D;
   logic          ld_start, run_start, halt;
   logic [3:0]    I;
   logic          CCn;
   logic [11:0]   D;
   logic          CI;
   logic [CW-1:0] CTRL;
   logic [1:0]    mode;

   ucode_fetch_if #(.MW(MW)) lif ();

   ucode_fetch #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .reset(reset), .Y(Y), .PLn(PLn), .MAPn(MAPn), .VECTn(VECTn),
      .COND(COND), .MAP_D(MAP_D), .VECT_D(VECT_D), .ld_start(ld_start),
      .run_start(run_start), .halt(halt), .ld(lif), .I(I), .CCn(CCn), .D(D),
      .CI(CI), .CTRL(CTRL), .mode(mode)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [MW-1:0] mdl [DEPTH];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [MW-1:0] fetch_word(input logic [11:0] a);
      return (int'(a) < DEPTH) ? mdl[a] : '0;
   endfunction

   function automatic logic exp_ccn(input logic [MW-1:0] w, input logic [7:0] c);
      int  sel;
      logic pol;
      sel = int'(w[MW-5 -: 3]);
      pol = w[MW-8];
      if (sel == 0) return 1'b0;
      return (c[sel] == pol) ? 1'b1 : 1'b0;
   endfunction

   function automatic logic [11:0] exp_d(input logic [MW-1:0] w, input logic pl, input logic mp,
                                         input logic vc, input logic [11:0] md, input logic [11:0] vd);
      if (!pl) return w[CW+11:CW];
      if (!mp) return md;
      if (!vc) return vd;
      return 12'h000;
   endfunction

   function automatic logic [MW-1:0] mkword(input logic [3:0] i, input int csel, input logic pol,
                                            input logic [11:0] br, input logic [CW-1:0] ctrl);
      return {i, 3'(csel), pol, br, ctrl};
   endfunction

   // Streams DEPTH words through the handshake; stall pattern and data chosen by 'mode_sel'.
   task automatic full_load(input int mode_sel);
      int acc;
      int cyc;
      logic v;
      logic [MW-1:0] w;
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      chk("load_enter_mode", 64'(mode), 64'(1));
      chk("load_enter_ready", 64'(lif.ld_ready), 64'(1));
      acc = 0;
      cyc = 0;
      while (acc < DEPTH && cyc < 2000) begin
         v = (mode_sel == 0) ? (cyc % 3 != 2) : ($urandom_range(0, 3) != 0);
         w = (mode_sel == 0) ? MW'(acc) : {4'($urandom), 32'($urandom)};
         lif.ld_valid = v;
         lif.ld_data  = w;
         tick();
         if (v) begin
            mdl[acc] = w;
            acc++;
         end
         if (acc == DEPTH - 1) chk("load_still_busy", 64'(mode), 64'(1));
         cyc++;
      end
      lif.ld_valid = 1'b0;
      chk("load_accepted_count", 64'(acc), 64'(DEPTH));
      chk("load_done_mode", 64'(mode), 64'(0));
      chk("load_done_ready", 64'(lif.ld_ready), 64'(0));
   endtask

   initial begin
      logic [MW-1:0] pipe;
      logic [MW-1:0] w;
      logic [MW-1:0] keep11;

      reset = 1'b0;
      Y = '0; PLn = 1'b1; MAPn = 1'b1; VECTn = 1'b1;
      COND = 8'hFF; MAP_D = '0; VECT_D = '0;
      ld_start = 1'b0; run_start = 1'b0; halt = 1'b0;
      lif.ld_valid = 1'b0; lif.ld_data = '0;
      #12;
      chk("rst_mode", 64'(mode), 64'(0));
      chk("rst_ready", 64'(lif.ld_ready), 64'(0));
      chk("rst_ci", 64'(CI), 64'(0));
      chk("rst_i", 64'(I), 64'(0));
      chk("rst_ctrl", 64'(CTRL), 64'(0));
      chk("rst_ccn", 64'(CCn), 64'(0));
      reset = 1'b1;
      tick();

      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("idle_halt_ignored", 64'(mode), 64'(0));

      // Full load with data = index, then read back 0x5A.
      full_load(0);
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      chk("run_enter_mode", 64'(mode), 64'(2));
      chk("run_ci", 64'(CI), 64'(1));
      chk("run_first_jz", 64'(CTRL), 64'(0));
      Y = 12'h05A;
      tick();
      chk("readback_5a_ctrl", 64'(CTRL), 64'h5A);
      chk("readback_5a_i", 64'(I), 64'(0));
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("halt_run_mode", 64'(mode), 64'(0));
      chk("halt_run_ctrl", 64'(CTRL), 64'(0));
      chk("halt_run_ci", 64'(CI), 64'(0));

      // Simultaneous start pulses: load has priority.
      ld_start = 1'b1; run_start = 1'b1;
      tick();
      ld_start = 1'b0; run_start = 1'b0;
      chk("start_priority", 64'(mode), 64'(1));
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("halt_load_mode", 64'(mode), 64'(0));

      // Random store contents, then random fetch traffic.
      full_load(1);
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      Y = 12'd3;
      tick();
      chk("lat_y3_ctrl", 64'(CTRL), 64'(mdl[3][CW-1:0]));
      chk("lat_y3_i", 64'(I), 64'(mdl[3][MW-1 -: 4]));
      Y = 12'd4;
      tick();
      chk("lat_y4_ctrl", 64'(CTRL), 64'(mdl[4][CW-1:0]));
      chk("lat_y4_i", 64'(I), 64'(mdl[4][MW-1 -: 4]));
      Y = 12'h300;
      tick();
      chk("oor_ctrl", 64'(CTRL), 64'(0));
      chk("oor_i", 64'(I), 64'(0));

      for (int k = 0; k < 300; k++) begin
         Y      = ($urandom_range(0, 4) == 0) ? 12'($urandom_range(DEPTH, 4095)) : 12'($urandom_range(0, DEPTH-1));
         COND   = 8'($urandom);
         PLn    = 1'($urandom); MAPn = 1'($urandom); VECTn = 1'($urandom);
         MAP_D  = 12'($urandom); VECT_D = 12'($urandom);
         pipe   = fetch_word(Y);
         tick();
         chk("rnd_i", 64'(I), 64'(pipe[MW-1 -: 4]));
         chk("rnd_ctrl", 64'(CTRL), 64'(pipe[CW-1:0]));
         chk("rnd_ccn", 64'(CCn), 64'(exp_ccn(pipe, COND)));
         chk("rnd_d", 64'(D), 64'(exp_d(pipe, PLn, MAPn, VECTn, MAP_D, VECT_D)));
      end
      halt = 1'b1;
      tick();
      halt = 1'b0;

      // Partial load: 10 words, then an 11th accepted together with halt.
      keep11 = mdl[11];
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         case (k)
            0:       w = mkword(AM_CJP, 5, 1'b0, 12'h123, 16'hBEEF);
            1:       w = mkword(AM_CJS, 5, 1'b1, 12'h321, 16'h1234);
            2:       w = mkword(AM_CONT, 0, 1'b1, 12'h0AA, 16'h5555);
            default: w = {4'($urandom), 32'($urandom)};
         endcase
         lif.ld_valid = 1'b1;
         lif.ld_data  = w;
         halt = (k == 10);
         tick();
         mdl[k] = w;
      end
      lif.ld_valid = 1'b0;
      halt = 1'b0;
      chk("partial_mode", 64'(mode), 64'(0));
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      Y = 12'd10;
      tick();
      chk("partial_w10", 64'(CTRL), 64'(mdl[10][CW-1:0]));
      Y = 12'd11;
      tick();
      chk("partial_w11_kept", 64'(CTRL), 64'(keep11[CW-1:0]));
      chk("partial_w11_i", 64'(I), 64'(keep11[MW-1 -: 4]));

      // D mux and condition on word 0 (BR=0x123, CSEL=5, POL=0).
      Y = 12'd0;
      COND = 8'b0010_0000;
      MAP_D = 12'h456; VECT_D = 12'h789;
      PLn = 1'b0; MAPn = 1'b1; VECTn = 1'b1;
      tick();
      chk("dmux_pl", 64'(D), 64'h123);
      chk("cond_pol0", 64'(CCn), 64'(0));
      PLn = 1'b1; MAPn = 1'b0; #1;
      chk("dmux_map", 64'(D), 64'h456);
      MAPn = 1'b1; VECTn = 1'b0; #1;
      chk("dmux_vect", 64'(D), 64'h789);
      VECTn = 1'b1; #1;
      chk("dmux_none", 64'(D), 64'h000);
      PLn = 1'b0; MAPn = 1'b0; #1;
      chk("dmux_pl_map", 64'(D), 64'h123);
      Y = 12'd1;
      tick();
      chk("cond_pol1", 64'(CCn), 64'(1));
      COND = 8'b0000_0000; #1;
      chk("cond_pol1_low", 64'(CCn), 64'(0));
      Y = 12'd2;
      tick();
      chk("cond_uncond", 64'(CCn), 64'(0));
      Y = 12'd0;
      tick();
      chk("pre_reset_i", 64'(I), 64'(AM_CJP));

      // Asynchronous reset between edges while running.
      #2;
      reset = 1'b0;
      #1;
      chk("async_i", 64'(I), 64'(0));
      chk("async_ctrl", 64'(CTRL), 64'(0));
      chk("async_ci", 64'(CI), 64'(0));
      chk("async_ready", 64'(lif.ld_ready), 64'(0));
      chk("async_mode", 64'(mode), 64'(0));
      reset = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
